// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: reset PC, redirect kinds, IFU state encoding
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam logic [1:0] REDIR_BR   = 2'b00;
  localparam logic [1:0] REDIR_J    = 2'b01;
  localparam logic [1:0] REDIR_JR   = 2'b10;
  localparam logic [1:0] REDIR_RSVD = 2'b11;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ifu_state_e;

endpackage

// File: rtl/npc.sv
// rtl/npc.sv - combinational redirect target computation for the fetch stage
module npc
  import cpu_pkg::*;
(
  input  logic [1:0]  redir_kind,
  input  logic [31:0] redir_base,
  input  logic [31:0] redir_off,
  input  logic [25:0] redir_idx,
  input  logic [31:0] redir_reg,
  output logic [31:0] target
);

  logic [31:0] seq_pc;

  assign seq_pc = redir_base + 32'd4;

  always_comb begin
    target = seq_pc + redir_off;
    case (redir_kind)
      REDIR_BR: target = seq_pc + redir_off;
      REDIR_J:  target = {seq_pc[31:28], redir_idx, 2'b00};
      // jr targets are taken verbatim; misalignment is caught at fetch time
      REDIR_JR: target = redir_reg;
      default:  target = seq_pc + redir_off;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch: PC register, ROM read, decode output register
module ifu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_instr,
  output logic [15:0]        id_imm,
  output logic               id_adel,
  input  logic               redir_valid,
  input  logic [1:0]         redir_kind,
  input  logic [31:0]        redir_base,
  input  logic [31:0]        redir_off,
  input  logic [25:0]        redir_idx,
  input  logic [31:0]        redir_reg
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_d, adel_d;
  logic [31:0] id_pc_d, instr_d;
  logic [31:0] target;
  logic        redir_take, load;

  npc u_npc (
    .redir_kind (redir_kind),
    .redir_base (redir_base),
    .redir_off  (redir_off),
    .redir_idx  (redir_idx),
    .redir_reg  (redir_reg),
    .target     (target)
  );

  assign imem_addr  = IMEM_AW'((pc_q - RESET_PC) >> 2);
  assign id_imm     = id_instr[15:0];
  assign redir_take = redir_valid && (redir_kind != REDIR_RSVD);
  assign load       = (state_q == RUN) && (!id_valid || id_ready);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = id_valid;
    id_pc_d = id_pc;
    instr_d = id_instr;
    adel_d  = id_adel;
    if (redir_take) begin
      // wrong-path entry is dropped even if decode is accepting it this cycle
      pc_d    = target;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (load) begin
      id_pc_d = pc_q;
      valid_d = 1'b1;
      if (pc_q[1:0] == 2'b00) begin
        instr_d = imem_rdata;
        adel_d  = 1'b0;
        pc_d    = pc_q + 32'd4;
      end else begin
        instr_d = 32'h0;
        adel_d  = 1'b1;
        state_d = HALT;
      end
    end else if ((state_q == HALT) && id_valid && id_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      id_valid <= 1'b0;
      id_pc    <= 32'h0;
      id_instr <= 32'h0;
      id_adel  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      id_valid <= valid_d;
      id_pc    <= id_pc_d;
      id_instr <= instr_d;
      id_adel  <= adel_d;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - directed bench for ifu with a fetch-level reference model
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [15:0] id_imm;
  logic        id_adel;
  logic        redir_valid = 1'b0;
  logic [1:0]  redir_kind = 2'b00;
  logic [31:0] redir_base = 32'h0;
  logic [31:0] redir_off = 32'h0;
  logic [25:0] redir_idx = 26'h0;
  logic [31:0] redir_reg = 32'h0;

  logic [31:0] rom [0:1023];

  int checks = 0;
  int errors = 0;

  ifu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_imm      (id_imm),
    .id_adel     (id_adel),
    .redir_valid (redir_valid),
    .redir_kind  (redir_kind),
    .redir_base  (redir_base),
    .redir_off   (redir_off),
    .redir_idx   (redir_idx),
    .redir_reg   (redir_reg)
  );

  assign imem_rdata = rom[imem_addr];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what decode should see, tracked per fetch transaction
  logic [31:0] m_pc = 32'h3000;
  logic        m_halt = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_idpc = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic        m_adel = 1'b0;

  function automatic logic [9:0] word_of(input logic [31:0] p);
    logic [31:0] w;
    w = (p - 32'h3000) / 4;
    return w[9:0];
  endfunction

  function automatic logic [31:0] redirect_to(input logic [1:0] k, input logic [31:0] b,
                                              input logic [31:0] o, input logic [25:0] i,
                                              input logic [31:0] r);
    logic [31:0] nxt;
    nxt = b + 32'd4;
    if (k == 2'b00) return nxt + o;
    if (k == 2'b01) return (nxt & 32'hF000_0000) | ({6'b0, i} * 4);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h3000; m_halt = 1'b0; m_valid = 1'b0;
      m_idpc = 32'h0; m_instr = 32'h0; m_adel = 1'b0;
    end else if (redir_valid && redir_kind != 2'b11) begin
      m_pc = redirect_to(redir_kind, redir_base, redir_off, redir_idx, redir_reg);
      m_valid = 1'b0;
      m_halt = 1'b0;
    end else if (!m_halt && (!m_valid || id_ready)) begin
      m_idpc = m_pc;
      m_valid = 1'b1;
      if (m_pc % 4 == 0) begin
        m_instr = rom[word_of(m_pc)];
        m_adel = 1'b0;
        m_pc = m_pc + 32'd4;
      end else begin
        m_instr = 32'h0;
        m_adel = 1'b1;
        m_halt = 1'b1;
      end
    end else if (m_halt && m_valid && id_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cyc_valid", {31'b0, id_valid}, {31'b0, m_valid});
    check("cyc_imem_addr", {22'b0, imem_addr}, {22'b0, word_of(m_pc)});
    if (m_valid) begin
      check("cyc_id_pc", id_pc, m_idpc);
      check("cyc_id_instr", id_instr, m_instr);
      check("cyc_id_imm", {16'b0, id_imm}, {16'b0, m_instr[15:0]});
      check("cyc_id_adel", {31'b0, id_adel}, {31'b0, m_adel});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [1:0] k, input logic [31:0] b, input logic [31:0] o,
                          input logic [25:0] i, input logic [31:0] r);
    redir_valid = 1'b1;
    redir_kind = k;
    redir_base = b;
    redir_off = o;
    redir_idx = i;
    redir_reg = r;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h2400_0000 + i;
    rom[0] = 32'h3c01_1234;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'b0, id_valid}, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_adel", {31'b0, id_adel}, 32'h0);
    check("rst_imem_addr", {22'b0, imem_addr}, 32'h0);

    id_ready = 1'b1;
    do_reset();
    step();
    check("t1_valid", {31'b0, id_valid}, 32'h1);
    check("t1_id_pc", id_pc, 32'h3000);
    check("t1_id_instr", id_instr, 32'h3c01_1234);
    check("t1_id_imm", {16'b0, id_imm}, 32'h1234);
    step();
    check("t1_id_pc_e2", id_pc, 32'h3004);

    do_reset();
    step();
    check("t2_id_pc_e1", id_pc, 32'h3000);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_stall_id_pc", id_pc, 32'h3000);
      check("t2_stall_addr", {22'b0, imem_addr}, 32'h1);
    end
    id_ready = 1'b1;
    step();
    check("t2_resume_id_pc", id_pc, 32'h3004);

    redirect(2'b00, 32'h3008, 32'hFFFF_FFF8, 26'h0, 32'h0);
    step();
    redir_valid = 1'b0;
    check("t3_bubble", {31'b0, id_valid}, 32'h0);
    check("t3_pc", {22'b0, imem_addr}, 32'h1);
    step();
    check("t3_id_pc", id_pc, 32'h3004);

    id_ready = 1'b0;
    step();
    check("t4_held", id_pc, 32'h3004);
    redirect(2'b01, 32'h3010, 32'h0, 26'h0000C05, 32'h0);
    step();
    redir_valid = 1'b0;
    check("t4_squash", {31'b0, id_valid}, 32'h0);
    check("t4_target_addr", {22'b0, imem_addr}, 32'h5);
    step();
    check("t4_id_pc", id_pc, 32'h3014);
    check("t4_id_instr", id_instr, 32'h2400_0005);
    id_ready = 1'b1;

    redirect(2'b11, 32'h0, 32'h0, 26'h0, 32'h3100);
    step();
    redir_valid = 1'b0;
    check("rsvd_ignored", id_pc, 32'h3018);

    redirect(2'b10, 32'h0, 32'h0, 26'h0, 32'h3002);
    step();
    redir_valid = 1'b0;
    id_ready = 1'b0;
    check("t5_bubble", {31'b0, id_valid}, 32'h0);
    step();
    check("t5_adel", {31'b0, id_adel}, 32'h1);
    check("t5_instr", id_instr, 32'h0);
    check("t5_id_pc", id_pc, 32'h3002);
    step();
    check("t5_adel_held", {31'b0, id_valid}, 32'h1);
    id_ready = 1'b1;
    step();
    check("t5_drained", {31'b0, id_valid}, 32'h0);
    step();
    check("t5_halted", {31'b0, id_valid}, 32'h0);
    redirect(2'b10, 32'h0, 32'h0, 26'h0, 32'h3000);
    step();
    redir_valid = 1'b0;
    step();
    check("t5_resume_pc", id_pc, 32'h3000);
    check("t5_resume_adel", {31'b0, id_adel}, 32'h0);

    redirect(2'b10, 32'h0, 32'h0, 26'h0, 32'hFFFF_FFFC);
    step();
    redir_valid = 1'b0;
    check("wrap_addr", {22'b0, imem_addr}, 32'h3FF);
    step();
    check("wrap_instr", id_instr, 32'h2400_03FF);
    check("wrap_pc_zero", {22'b0, imem_addr}, 32'h0);
    step();
    check("wrap_id_pc", id_pc, 32'h0);

    id_ready = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_valid", {31'b0, id_valid}, 32'h0);
    check("t6_async_addr", {22'b0, imem_addr}, 32'h0);
    step();
    rst_n = 1'b1;
    id_ready = 1'b1;
    step();
    check("t6_restart", id_pc, 32'h3000);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
